// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, coin-value slicing and index-width helpers for the vending controller.
package vend_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, VEND = 2'd1, CHANGE = 2'd2, HOLD = 2'd3} vend_state_t;
  localparam int MAX_VALS_W = 256;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int CHG_IDX_W = idx_w(3);
  function automatic logic [31:0] coin_val(input logic [MAX_VALS_W-1:0] vals, input int val_w, input int idx);
    logic [MAX_VALS_W-1:0] m;
    m = (MAX_VALS_W'(1) << val_w) - MAX_VALS_W'(1);
    return 32'((vals >> (idx * val_w)) & m);
  endfunction
endpackage

// File: rtl/vend_ctrl_param_sync_edge.sv
// vend_sync_edge: two-flop synchronizer followed by a registered rising-edge detector.
module vend_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [2:0] sync_q, sync_d;
  logic rise_q, rise_d;
  always_comb begin
    sync_d = {sync_q[1:0], d};
    rise_d = sync_q[1] & ~sync_q[2];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: parametrised vending controller with saturating credit, vend pulse and change handshake.
// Define VEND_AUTO_CHANGE_EN to pay out leftover credit automatically after each vend.
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int NUM_COINS = 3,
  parameter int VAL_W = 8,
  parameter logic [NUM_COINS*VAL_W-1:0] COIN_VALUES = {8'd25, 8'd10, 8'd5},
  parameter logic [VAL_W-1:0] PRICE = 8'd35,
  parameter logic [VAL_W-1:0] MAX_CREDIT = 8'd200,
  parameter int VEND_CYCLES = 4,
  localparam int IDX_W = idx_w(NUM_COINS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_COINS-1:0] coin_in,
  input  logic                 buy,
  input  logic                 refund,
  input  logic                 chg_ack,
  output logic [VAL_W-1:0]     credit,
  output logic                 vend,
  output logic                 chg_req,
  output logic [IDX_W-1:0]     chg_idx,
  output logic                 reject,
  output logic                 err,
  output logic [1:0]           state
);
  localparam int CNT_W = idx_w(VEND_CYCLES);
  localparam logic [MAX_VALS_W-1:0] CV = MAX_VALS_W'(COIN_VALUES);
  function automatic logic [VAL_W-1:0] val(input int idx);
    return VAL_W'(coin_val(CV, VAL_W, idx));
  endfunction
  // Values ascend with index, so the last fitting index is the largest coin.
  function automatic logic [IDX_W-1:0] pick(input logic [VAL_W-1:0] c);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_COINS; k++) if (val(k) <= c) r = IDX_W'(k);
    return r;
  endfunction
  logic [NUM_COINS+1:0] raw, rise;
  vend_state_t state_q, state_d, vend_exit;
  logic [VAL_W-1:0] credit_q, credit_d;
  logic [IDX_W-1:0] chg_idx_q, chg_idx_d, coin_sel;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VAL_W:0] sum;
  logic vend_q, vend_d, chg_req_q, chg_req_d, reject_q, reject_d, err_q, err_d, coin_hit;
  assign raw = {refund, buy, coin_in};
  for (genvar i = 0; i < NUM_COINS + 2; i++) begin : g_se
    vend_sync_edge u_se (.clk(clk), .rst_n(rst_n), .d(raw[i]), .rise(rise[i]));
  end
`ifdef VEND_AUTO_CHANGE_EN
  assign vend_exit = (credit_q != '0) ? CHANGE : IDLE;
`else
  assign vend_exit = IDLE;
`endif
  always_comb begin
    state_d = state_q;
    credit_d = credit_q;
    vend_d = vend_q;
    chg_req_d = chg_req_q;
    chg_idx_d = chg_idx_q;
    cnt_d = cnt_q;
    reject_d = 1'b0;
    err_d = 1'b0;
    coin_hit = 1'b0;
    coin_sel = '0;
    for (int k = NUM_COINS - 1; k >= 0; k--) if (rise[k]) begin
      coin_hit = 1'b1;
      coin_sel = IDX_W'(k);
    end
    sum = {1'b0, credit_q} + {1'b0, val(int'(coin_sel))};
    if (ena) begin
      case (state_q)
        IDLE:
          if (rise[NUM_COINS+1]) state_d = (credit_q != '0) ? CHANGE : IDLE;
          else if (rise[NUM_COINS]) begin
            if (credit_q >= PRICE) begin
              credit_d = credit_q - PRICE;
              state_d = VEND;
              vend_d = 1'b1;
              cnt_d = '0;
            end else err_d = 1'b1;
          end else if (coin_hit) begin
            if (sum > {1'b0, MAX_CREDIT}) reject_d = 1'b1;
            else credit_d = sum[VAL_W-1:0];
          end
        VEND:
          if (cnt_q == CNT_W'(VEND_CYCLES - 1)) begin
            vend_d = 1'b0;
            state_d = vend_exit;
          end else cnt_d = cnt_q + CNT_W'(1);
        CHANGE:
          // First CHANGE cycle raises the request; each ack re-selects from the reduced credit.
          if (!chg_req_q || chg_ack) begin
            credit_d = chg_req_q ? credit_q - val(int'(chg_idx_q)) : credit_q;
            chg_req_d = credit_d >= val(0);
            chg_idx_d = pick(credit_d);
            state_d = chg_req_d ? CHANGE : IDLE;
          end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      credit_q <= '0;
      vend_q <= 1'b0;
      chg_req_q <= 1'b0;
      chg_idx_q <= '0;
      cnt_q <= '0;
      reject_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      vend_q <= vend_d;
      chg_req_q <= chg_req_d;
      chg_idx_q <= chg_idx_d;
      cnt_q <= cnt_d;
      reject_q <= reject_d;
      err_q <= err_d;
    end
  end
  assign credit = credit_q;
  assign vend = vend_q;
  assign chg_req = chg_req_q;
  assign chg_idx = chg_idx_q;
  assign reject = reject_q;
  assign err = err_q;
  assign state = state_q;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param: directed scenarios plus randomized transactions checked against a transaction-level model.
module tb_vend_ctrl_param;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, buy = 1'b0, refund = 1'b0, chg_ack = 1'b0;
  logic [2:0] coin_in = '0;
  logic [7:0] credit;
  logic vend, chg_req, reject, err;
  logic [1:0] chg_idx, state, hold_idx;
  int n_run = 0, n_fail = 0, rej_cnt = 0, err_cnt = 0, vend_cnt = 0, ack_delay = 0, wcnt = 0;
  int mc, me, mr, mv, r0;
  int got_q[$], exp_q[$];
  int vals[3] = '{5, 10, 25};

  always #5 clk = ~clk;

  vend_ctrl_param dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .coin_in(coin_in), .buy(buy), .refund(refund),
    .chg_ack(chg_ack), .credit(credit), .vend(vend), .chg_req(chg_req), .chg_idx(chg_idx),
    .reject(reject), .err(err), .state(state)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] m);
    {refund, buy, coin_in} = m;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((state != 2'd0 || chg_req) && n < 400) begin
      tick(1);
      n++;
    end
    if (n >= 400) chk("settle_timeout", n, 0);
  endtask

  task automatic pulse(input logic [4:0] m);
    press(m);
    tick(1);
    press(5'd0);
    tick(4);
    settle();
    tick(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic give_change();
    int j;
    while (mc >= vals[0]) begin
      j = 0;
      for (int k = 0; k < 3; k++) if (vals[k] <= mc) j = k;
      exp_q.push_back(j);
      mc -= vals[j];
    end
  endtask

  task automatic cmp_change(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Pulse and vend-cycle counters observed mid-cycle.
  always @(negedge clk) if (rst_n) begin
    rej_cnt += int'(reject);
    err_cnt += int'(err);
    vend_cnt += int'(vend);
  end

  // Dispenser: acks after ack_delay waiting cycles, and watches the index stay put meanwhile.
  always @(negedge clk) begin
    if (!rst_n || !chg_req || chg_ack) begin
      chg_ack = 1'b0;
      wcnt = 0;
    end else begin
      if (wcnt == 0) hold_idx = chg_idx;
      else chk("idx_stable", int'(chg_idx), int'(hold_idx));
      if (wcnt >= ack_delay) begin
        chg_ack = 1'b1;
        got_q.push_back(int'(chg_idx));
      end
      wcnt++;
    end
  end

  task automatic txn();
    logic [4:0] m;
    int r, k;
    r = $urandom_range(0, 15);
    m[4] = (r <= 1);
    m[3] = (r >= 1 && r <= 4);
    m[2:0] = (r >= 3) ? 3'($urandom_range(1, 7)) : 3'd0;
    ack_delay = $urandom_range(0, 3);
    if (m[4]) begin
      if (mc > 0) give_change();
    end else if (m[3]) begin
      if (mc >= 35) begin
        mc -= 35;
        mv += 4;
`ifdef VEND_AUTO_CHANGE_EN
        give_change();
`endif
      end else me++;
    end else if (m[2:0] != 3'd0) begin
      k = m[0] ? 0 : m[1] ? 1 : 2;
      if (mc + vals[k] > 200) mr++;
      else mc += vals[k];
    end
    press(m);
    tick($urandom_range(1, 3));
    press(5'd0);
    tick(4);
    settle();
    tick(1);
    chk("rand_credit", int'(credit), mc);
    chk("rand_reject", rej_cnt, mr);
    chk("rand_err", err_cnt, me);
    chk("rand_vend", vend_cnt, mv);
    chk("rand_state", int'(state), 0);
    cmp_change("rand_chg");
  endtask

  initial begin
    int n;
    do_reset();
    chk("rst_credit", int'(credit), 0);
    chk("rst_vend", int'(vend), 0);
    chk("rst_chg_req", int'(chg_req), 0);
    chk("rst_chg_idx", int'(chg_idx), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_state", int'(state), 0);

    press(5'b00100);
    tick(3);
    chk("latency_credit", int'(credit), 0);
    tick(1);
    chk("coin2_credit", int'(credit), 25);
    press(5'd0);
    tick(4);
    press(5'b00010);
    tick(4);
    chk("coin1_credit", int'(credit), 35);
    press(5'd0);
    tick(4);
    press(5'b01000);
    tick(4);
    chk("buy_state", int'(state), 1);
    chk("buy_vend_on", int'(vend), 1);
    chk("buy_credit", int'(credit), 0);
    press(5'd0);
    tick(3);
    chk("vend_hold", int'(vend), 1);
    tick(1);
    chk("vend_off", int'(vend), 0);
    chk("vend_idle", int'(state), 0);

    do_reset();
    repeat (2) pulse(5'b00100);
    chk("fifty_credit", int'(credit), 50);
    got_q.delete();
    ack_delay = 0;
    pulse(5'b01000);
`ifdef VEND_AUTO_CHANGE_EN
    exp_q = '{1, 0};
    chk("auto_credit", int'(credit), 0);
`else
    chk("keep_credit", int'(credit), 15);
`endif
    cmp_change("auto_chg");

    do_reset();
    pulse(5'b00010);
    press(5'b01000);
    tick(4);
    chk("err_pulse", int'(err), 1);
    tick(1);
    chk("err_end", int'(err), 0);
    chk("err_credit", int'(credit), 10);
    chk("err_state", int'(state), 0);
    press(5'd0);
    tick(4);

    do_reset();
    repeat (7) pulse(5'b00100);
    pulse(5'b00010);
    pulse(5'b00001);
    chk("c190_credit", int'(credit), 190);
    press(5'b00100);
    tick(4);
    chk("reject_pulse", int'(reject), 1);
    chk("reject_credit", int'(credit), 190);
    tick(1);
    chk("reject_end", int'(reject), 0);
    press(5'd0);
    tick(4);
    pulse(5'b00001);
    chk("c195_credit", int'(credit), 195);

    do_reset();
    pulse(5'b00100);
    pulse(5'b00010);
    pulse(5'b00001);
    got_q.delete();
    ack_delay = 3;
    pulse(5'b10000);
    exp_q = '{2, 1, 0};
    cmp_change("refund_chg");
    chk("refund_credit", int'(credit), 0);

    do_reset();
    pulse(5'b00100);
    ack_delay = 1000;
    press(5'b10000);
    tick(1);
    press(5'd0);
    n = 0;
    while (!chg_req && n < 20) begin
      tick(1);
      n++;
    end
    chk("mid_chg_req", int'(chg_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_credit", int'(credit), 0);
    chk("arst_chg_req", int'(chg_req), 0);
    chk("arst_state", int'(state), 0);
    chk("arst_chg_idx", int'(chg_idx), 0);
    tick(1);
    rst_n = 1'b1;
    ack_delay = 0;
    tick(2);
    got_q.delete();

    r0 = rej_cnt;
    pulse(5'b00101);
    chk("simul_credit", int'(credit), 5);
    chk("simul_noreject", rej_cnt, r0);
    ena = 1'b0;
    press(5'b00010);
    tick(1);
    press(5'd0);
    tick(5);
    ena = 1'b1;
    tick(2);
    chk("frozen_credit", int'(credit), 5);
    pulse(5'b00010);
    chk("thaw_credit", int'(credit), 15);

    do_reset();
    rej_cnt = 0;
    err_cnt = 0;
    vend_cnt = 0;
    mc = 0;
    me = 0;
    mr = 0;
    mv = 0;
    got_q.delete();
    exp_q.delete();
    repeat (150) txn();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
